// File: rtl/btn_seq_player.sv
// Replays a stored list of button codes as press/release waveforms on five
// registered button lines, with a fixed hold time and release gap per entry.
module btn_seq_player #(
  parameter int DEPTH        = 16,
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [$clog2(DEPTH):0]     seq_len,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [2:0]                 wr_code,
  output logic                       up_btn,
  output logic                       down_btn,
  output logic                       left_btn,
  output logic                       right_btn,
  output logic                       mid_btn,
  output logic                       busy,
  output logic                       done
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LEN_W = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_FIN
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         btn_q, btn_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2:0]         mem_q [DEPTH];
  logic [2:0]         mem_d [DEPTH];
  logic [LEN_W-1:0]   len_clamped;
  logic [AW-1:0]      idx_next;

  // One-hot line vector: bit 0 up, 1 down, 2 left, 3 right, 4 mid.
  function automatic logic [4:0] decode_code(input logic [2:0] code);
    case (code)
      3'd1:    decode_code = 5'b00001;
      3'd2:    decode_code = 5'b00010;
      3'd3:    decode_code = 5'b00100;
      3'd4:    decode_code = 5'b01000;
      3'd5:    decode_code = 5'b10000;
      default: decode_code = 5'b00000;
    endcase
  endfunction

  function automatic logic [2:0] default_code(input int i);
    case (i)
      0:       default_code = 3'd1;
      1:       default_code = 3'd2;
      2:       default_code = 3'd3;
      3:       default_code = 3'd4;
      default: default_code = 3'd0;
    endcase
  endfunction

  assign len_clamped = (seq_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : seq_len;
  assign idx_next    = idx_q + 1'b1;

  // Writes are only accepted in IDLE and land before a same-cycle start reads entry 0.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && state_q == S_IDLE) begin
      mem_d[wr_addr] = wr_code;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    btn_d   = 5'b00000;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d = len_clamped;
          idx_d = '0;
          if (len_clamped != '0) begin
            state_d = S_PRESS;
            cnt_d   = CNT_W'(PRESS_CYCLES - 1);
            btn_d   = decode_code(mem_d[0]);
            busy_d  = 1'b1;
          end else begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end
        end
      end
      S_PRESS: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
          btn_d = btn_q;
        end
      end
      S_GAP: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          if ({1'b0, idx_q} == len_q - 1'b1) begin
            state_d = S_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_PRESS;
            idx_d   = idx_next;
            cnt_d   = CNT_W'(PRESS_CYCLES - 1);
            btn_d   = decode_code(mem_q[idx_next]);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort outranks everything, including a same-cycle start.
    if (abort) begin
      state_d = S_IDLE;
      btn_d   = 5'b00000;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      btn_q   <= 5'b00000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= default_code(i);
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
    end
  end

  assign up_btn    = btn_q[0];
  assign down_btn  = btn_q[1];
  assign left_btn  = btn_q[2];
  assign right_btn = btn_q[3];
  assign mid_btn   = btn_q[4];
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_btn_seq_player.sv
// Scoreboard bench for btn_seq_player: stimulus queues the expected per-cycle
// output vector {done,busy,mid,right,left,down,up}; a monitor pops and compares.
module tb_btn_seq_player;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort, wr_en;
  logic [AW:0]   seq_len;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_code;
  logic          up_btn, down_btn, left_btn, right_btn, mid_btn, busy, done;

  btn_seq_player #(.DEPTH(DEPTH), .PRESS_CYCLES(4), .GAP_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seq_len(seq_len),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
    .up_btn(up_btn), .down_btn(down_btn), .left_btn(left_btn),
    .right_btn(right_btn), .mid_btn(mid_btn), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [6:0] exp_q [$];
  logic [6:0] tr [$];
  logic [2:0] codes [DEPTH];
  logic [6:0] mon_e, mon_a;
  string      tag;
  int         cyc;
  int         checks = 0;
  int         errors = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {done, busy, mid_btn, right_btn, left_btn, down_btn, up_btn};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL %s cycle %0d: got {done,busy,m,r,l,d,u}=%b expected %b",
                 tag, cyc, mon_a, mon_e);
      end
    end
  end

  function automatic logic [4:0] btn_of(input logic [2:0] c);
    case (c)
      3'd1:    btn_of = 5'b00001;
      3'd2:    btn_of = 5'b00010;
      3'd3:    btn_of = 5'b00100;
      3'd4:    btn_of = 5'b01000;
      3'd5:    btn_of = 5'b10000;
      default: btn_of = 5'b00000;
    endcase
  endfunction

  task automatic tick(input logic [6:0] e);
    @(posedge clk);
    exp_q.push_back(e);
    cyc++;
    #1;
    start = 1'b0;
    abort = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(7'b0);
  endtask

  // Expected waveform: each entry held 4 cycles, then 4 released, then a done pulse.
  task automatic add_play(input int n);
    tr.delete();
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) tr.push_back({2'b01, btn_of(codes[i])});
      for (int k = 0; k < 4; k++) tr.push_back(7'b0100000);
    end
    tr.push_back(7'b1000000);
  endtask

  task automatic run_tr();
    while (tr.size() > 0) tick(tr.pop_front());
  endtask

  task automatic set_default_codes();
    for (int i = 0; i < DEPTH; i++) codes[i] = 3'd0;
    codes[0] = 3'd1; codes[1] = 3'd2; codes[2] = 3'd3; codes[3] = 3'd4;
  endtask

  task automatic write_entry(input int a, input logic [2:0] c);
    wr_en = 1'b1; wr_addr = AW'(a); wr_code = c;
    tick(7'b0);
  endtask

  task automatic begin_play(input int len, input string t);
    tag = t; cyc = 0;
    seq_len = (AW+1)'(len);
    start = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; wr_en = 1'b0;
    seq_len = '0; wr_addr = '0; wr_code = '0;
    tag = "reset"; cyc = 0;
    set_default_codes();
    tick(7'b0); tick(7'b0);
    rst = 1'b0;
    idle(2);

    // Default unlock sequence.
    begin_play(4, "default4");
    add_play(4); run_tr(); idle(2);

    // Rewritten entries: mid, then a silent entry.
    tag = "write"; write_entry(0, 3'd5); write_entry(1, 3'd0);
    codes[0] = 3'd5; codes[1] = 3'd0;
    begin_play(2, "mid_none");
    add_play(2); run_tr(); idle(2);

    // Zero length: immediate done, nothing else.
    begin_play(0, "len0");
    tick(7'b1000000); idle(2);

    tag = "reset2"; rst = 1'b1; tick(7'b0); rst = 1'b0; tick(7'b0);
    set_default_codes();

    // Abort during the second press, then replay from entry 0.
    begin_play(4, "abort");
    add_play(4);
    for (int k = 0; k < 10; k++) tick(tr.pop_front());
    abort = 1'b1; tick(7'b0); tr.delete(); idle(3);
    tag = "abort_start"; start = 1'b1; abort = 1'b1; seq_len = 5'd4;
    tick(7'b0); idle(2);
    begin_play(4, "replay");
    add_play(4); run_tr(); idle(2);

    // Start, write and seq_len change during playback are all ignored.
    begin_play(4, "busy_ignore");
    add_play(4);
    for (int k = 0; tr.size() > 0; k++) begin
      if (k == 9) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_code = 3'd5; seq_len = 5'd1;
      end
      tick(tr.pop_front());
    end
    idle(3);
    begin_play(3, "entry2_kept");
    add_play(3); run_tr(); idle(2);

    // Write and start together: playback sees the new entry 0.
    tag = "wr_start"; cyc = 0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_code = 3'd4; start = 1'b1; seq_len = 5'd1;
    codes[0] = 3'd4;
    add_play(1); run_tr(); idle(2);

    // Reset mid-playback restores the default table.
    begin_play(4, "rst_mid");
    add_play(4);
    for (int k = 0; k < 5; k++) tick(tr.pop_front());
    rst = 1'b1; tick(7'b0); tr.delete(); rst = 1'b0; tick(7'b0);
    set_default_codes();
    begin_play(4, "after_rst");
    add_play(4); run_tr(); idle(2);

    // Oversized length clamps to DEPTH; last entry made audible.
    tag = "write15"; write_entry(15, 3'd5);
    codes[15] = 3'd5;
    begin_play(31, "clamp16");
    add_play(16); run_tr(); idle(2);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
